ring_cadence_ctrl: RTL and testbench

//  Sequences the phone alert actuators for an incoming call: drives ringer (vibrate_mode=0) or motor
//  (vibrate_mode=1) in an ON/OFF cadence, honours answer/silence, times out to a missed-call event.

---
 rtl/ringer_pkg.sv | 27 ++
 rtl/ring_cadence_ctrl_if.sv | 23 ++
 rtl/ring_timer.sv | 41 ++++
 rtl/ring_cadence_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ring_cadence_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ringer_pkg.sv
// Shared state encoding and default cadence constants for the incoming-call alert sequencer.
package ringer_pkg;

    localparam int unsigned DEF_ON_CYCLES  = 8;
    localparam int unsigned DEF_OFF_CYCLES = 4;
    localparam int unsigned DEF_MAX_BURSTS = 3;
    localparam int unsigned DEF_ESC_BURSTS = 2;

    typedef enum logic [2:0] {
        RS_IDLE  = 3'd0,
        RS_ON    = 3'd1,
        RS_OFF   = 3'd2,
        RS_MUTED = 3'd3,
        RS_DONE  = 3'd4
    } ring_state_e;

    localparam logic [2:0] ST_IDLE  = RS_IDLE;
    localparam logic [2:0] ST_ON    = RS_ON;
    localparam logic [2:0] ST_OFF   = RS_OFF;
    localparam logic [2:0] ST_MUTED = RS_MUTED;
    localparam logic [2:0] ST_DONE  = RS_DONE;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ring_cadence_ctrl_if.sv
// Call-signalling inputs and actuator outputs of the alert sequencer, grouped as one bundle.
interface ring_cadence_ctrl_if;

    logic ring_req;
    logic vibrate_mode;
    logic answer;
    logic silence;
    logic ringer;
    logic motor;
    logic busy;
    logic missed_call;

    modport master (
        output ring_req, vibrate_mode, answer, silence,
        input  ringer, motor, busy, missed_call
    );

    modport slave (
        input  ring_req, vibrate_mode, answer, silence,
        output ringer, motor, busy, missed_call
    );

endinterface

// File: rtl/ring_timer.sv
// Loadable saturating up-counter with hold and terminal-count flag; one instance times both cadence phases.
module ring_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             clear_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // next count: clear wins over hold, saturate instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (hold_i) begin
            cnt_d = cnt_q;
        end else if (cnt_q == {WIDTH{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/ring_cadence_ctrl.sv
// Incoming-call alert sequencer: ON/OFF cadence on ringer or motor, answer/silence handling, missed-call pulse.
// Optional build macro RING_ESCALATE_EN: late vibrate bursts also drive the ringer.
module ring_cadence_ctrl
    import ringer_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int unsigned MAX_BURSTS = DEF_MAX_BURSTS,
    parameter int unsigned ESC_BURSTS = DEF_ESC_BURSTS
) (
    input  logic               clk,
    input  logic               areset_n,
    ring_cadence_ctrl_if.slave bus
);

    localparam int unsigned TMR_W   = $clog2(max_u(ON_CYCLES, OFF_CYCLES) + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURSTS + 1);

    localparam logic [TMR_W-1:0]   ON_TERM   = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]   OFF_TERM  = TMR_W'(OFF_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURSTS);
    localparam logic [BURST_W-1:0] BURST_ESC = BURST_W'(ESC_BURSTS);

`ifdef RING_ESCALATE_EN
    localparam logic ESC_EN = 1'b1;
`else
    localparam logic ESC_EN = 1'b0;
`endif

    logic [2:0]         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               missed_q, missed_d;
    logic               tmr_clear_s;
    logic               tmr_hold_s;
    logic [TMR_W-1:0]   tmr_term_s;
    logic               tmr_tc_s;
    logic               ringer_s;
    logic               motor_s;

    ring_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .areset_n (areset_n),
        .clear_i  (tmr_clear_s),
        .hold_i   (tmr_hold_s),
        .term_i   (tmr_term_s),
        .tc_o     (tmr_tc_s)
    );

    // state transitions; answer > ring_req drop > silence > cadence timer while a call is alerting
    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        missed_d    = 1'b0;
        tmr_clear_s = 1'b0;
        tmr_hold_s  = 1'b0;
        tmr_term_s  = ON_TERM;
        case (state_q)
            ST_IDLE: begin
                tmr_clear_s = 1'b1;
                if (bus.ring_req) begin
                    state_d = ST_ON;
                    burst_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ON: begin
                tmr_term_s = ON_TERM;
                if (bus.answer) begin
                    state_d     = ST_IDLE;
                    tmr_clear_s = 1'b1;
                end else if (!bus.ring_req) begin
                    state_d     = ST_IDLE;
                    missed_d    = 1'b1;
                    tmr_clear_s = 1'b1;
                end else if (bus.silence) begin
                    state_d    = ST_MUTED;
                    tmr_hold_s = 1'b1;
                end else if (tmr_tc_s) begin
                    state_d     = ST_OFF;
                    tmr_clear_s = 1'b1;
                    if (burst_q != BURST_MAX) begin
                        burst_d = burst_q + BURST_W'(1);
                    end else begin
                        burst_d = burst_q;
                    end
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_OFF: begin
                tmr_term_s = OFF_TERM;
                if (bus.answer) begin
                    state_d     = ST_IDLE;
                    tmr_clear_s = 1'b1;
                end else if (!bus.ring_req) begin
                    state_d     = ST_IDLE;
                    missed_d    = 1'b1;
                    tmr_clear_s = 1'b1;
                end else if (bus.silence) begin
                    state_d    = ST_MUTED;
                    tmr_hold_s = 1'b1;
                end else if (tmr_tc_s) begin
                    tmr_clear_s = 1'b1;
                    if (burst_q < BURST_MAX) begin
                        state_d = ST_ON;
                    end else begin
                        state_d  = ST_DONE;
                        missed_d = 1'b1;
                    end
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_MUTED: begin
                tmr_hold_s = 1'b1;
                if (bus.answer) begin
                    state_d     = ST_IDLE;
                    tmr_clear_s = 1'b1;
                end else if (!bus.ring_req) begin
                    state_d     = ST_IDLE;
                    missed_d    = 1'b1;
                    tmr_clear_s = 1'b1;
                end else begin
                    state_d = ST_MUTED;
                end
            end
            ST_DONE: begin
                tmr_clear_s = 1'b1;
                if (!bus.ring_req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                burst_d     = '0;
                tmr_clear_s = 1'b1;
            end
        endcase
    end

    // FSM, burst counter and missed-call pulse registers
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= ST_IDLE;
            burst_q  <= '0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            missed_q <= missed_d;
        end
    end

    // actuator decode follows vibrate_mode live so a mid-burst toggle switches the same cycle
    always_comb begin
        ringer_s = 1'b0;
        motor_s  = 1'b0;
        if (state_q == ST_ON) begin
            motor_s  = bus.vibrate_mode;
            ringer_s = ~bus.vibrate_mode |
                       (ESC_EN & bus.vibrate_mode & (burst_q >= BURST_ESC));
        end else begin
            ringer_s = 1'b0;
            motor_s  = 1'b0;
        end
    end

    assign bus.ringer      = ringer_s;
    assign bus.motor       = motor_s;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.missed_call = missed_q;

endmodule

// File: tb/tb_ring_cadence_ctrl.sv
// Self-checking bench for ring_cadence_ctrl: directed table, hand sequences and a random run against a timeline model.
module tb_ring_cadence_ctrl;

    localparam int ON_C  = 4;
    localparam int OFF_C = 2;
    localparam int MAX_C = 3;
    localparam int ESC_C = 2;
    localparam int P     = ON_C + OFF_C;
`ifdef RING_ESCALATE_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    ring_cadence_ctrl_if bus_if ();

    ring_cadence_ctrl #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .MAX_BURSTS (MAX_C),
        .ESC_BURSTS (ESC_C)
    ) dut (
        .clk      (clk),
        .areset_n (rst_n),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: 0 idle, 1 alerting, 2 muted, 3 finished; t = cycles since alerting began.
    int m_st;
    int m_t;
    bit m_missed;

    typedef struct {
        bit rr, vm, an, si;
        bit er, em, eb, emc;
    } vec_t;
    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_st = 0;
        m_t = 0;
        m_missed = 1'b0;
    endtask

    task automatic model_edge(input bit rr, input bit an, input bit si);
        m_missed = 1'b0;
        case (m_st)
            0: if (rr) begin m_st = 1; m_t = 0; end
            1: begin
                if (an) m_st = 0;
                else if (!rr) begin m_st = 0; m_missed = 1'b1; end
                else if (si) m_st = 2;
                else begin
                    m_t++;
                    if (m_t == MAX_C * P) begin m_st = 3; m_missed = 1'b1; end
                end
            end
            2: begin
                if (an) m_st = 0;
                else if (!rr) begin m_st = 0; m_missed = 1'b1; end
            end
            default: if (!rr) m_st = 0;
        endcase
    endtask

    // Drive one cycle, sample mid-cycle, compare against the model, then advance past the edge.
    task automatic apply(input bit rr, input bit vm, input bit an, input bit si,
                         output bit r, output bit m, output bit b, output bit mc);
        bit on, er, em;
        bus_if.ring_req     = rr;
        bus_if.vibrate_mode = vm;
        bus_if.answer       = an;
        bus_if.silence      = si;
        @(negedge clk);
        r  = bus_if.ringer;
        m  = bus_if.motor;
        b  = bus_if.busy;
        mc = bus_if.missed_call;
        on = (m_st == 1) && ((m_t % P) < ON_C);
        em = on && vm;
        er = on && (!vm || (ESC_EN && (m_t / P) >= ESC_C));
        chk("model_ringer", 32'(r), 32'(er));
        chk("model_motor", 32'(m), 32'(em));
        chk("model_busy", 32'(b), 32'(m_st != 0));
        chk("model_missed", 32'(mc), 32'(m_missed));
        @(posedge clk);
        model_edge(rr, an, si);
        #1;
    endtask

    initial begin
        bit r, m, b, mc;
        bit rr_p;
        logic [22:0] ring_pat;
        logic [22:0] miss_pat;
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        bus_if.ring_req     = 1'b0;
        bus_if.vibrate_mode = 1'b0;
        bus_if.answer       = 1'b0;
        bus_if.silence      = 1'b0;
        model_reset();

        vecs[0]  = '{1,0,0,0, 0,0,0,0};
        vecs[1]  = '{1,0,0,0, 1,0,1,0};
        vecs[2]  = '{1,0,0,1, 1,0,1,0};
        vecs[3]  = '{1,0,0,0, 0,0,1,0};
        vecs[4]  = '{1,0,0,0, 0,0,1,0};
        vecs[5]  = '{0,0,0,0, 0,0,1,0};
        vecs[6]  = '{0,0,0,0, 0,0,0,1};
        vecs[7]  = '{0,0,0,0, 0,0,0,0};
        vecs[8]  = '{1,1,0,0, 0,0,0,0};
        vecs[9]  = '{1,1,0,0, 0,1,1,0};
        vecs[10] = '{1,1,0,0, 0,1,1,0};
        vecs[11] = '{1,1,0,0, 0,1,1,0};
        vecs[12] = '{1,1,0,0, 0,1,1,0};
        vecs[13] = '{1,1,0,0, 0,0,1,0};
        vecs[14] = '{1,1,0,0, 0,0,1,0};
        vecs[15] = '{1,1,0,0, 0,1,1,0};
        vecs[16] = '{1,1,1,0, 0,1,1,0};
        vecs[17] = '{0,1,0,0, 0,0,0,0};
        vecs[18] = '{0,1,0,0, 0,0,0,0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ringer", 32'(bus_if.ringer), 32'd0);
        chk("rst_motor", 32'(bus_if.motor), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_missed", 32'(bus_if.missed_call), 32'd0);
        rst_n = 1'b1;

        // Reset during ON aborts with no missed-call pulse
        for (int c = 0; c < 3; c++) apply(1'b1, 1'b0, 1'b0, 1'b0, r, m, b, mc);
        chk("pre_rst_ringer", 32'(bus_if.ringer), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ringer", 32'(bus_if.ringer), 32'd0);
        chk("async_rst_busy", 32'(bus_if.busy), 32'd0);
        model_reset();
        bus_if.ring_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, r, m, b, mc);
            chk("post_rst_missed", 32'(mc), 32'd0);
        end

        // Full unanswered call on the ringer
        ring_pat = 23'b000000_1111_00_1111_00_1111_0;
        miss_pat = 23'd1 << 19;
        for (int c = 0; c < 23; c++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, r, m, b, mc);
            chk($sformatf("cad_ringer_c%0d", c), 32'(r), 32'(ring_pat[c]));
            chk($sformatf("cad_missed_c%0d", c), 32'(mc), 32'(miss_pat[c]));
            chk($sformatf("cad_busy_c%0d", c), 32'(b), 32'(c != 0));
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, r, m, b, mc);
        chk("done_busy_hold", 32'(b), 32'd1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, r, m, b, mc);
        chk("done_busy_clear", 32'(b), 32'd0);
        chk("done_no_second_pulse", 32'(mc), 32'd0);

        // Silence/drop and answer table
        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].rr, vecs[i].vm, vecs[i].an, vecs[i].si, r, m, b, mc);
            chk($sformatf("tbl%0d_ringer", i), 32'(r), 32'(vecs[i].er));
            chk($sformatf("tbl%0d_motor", i), 32'(m), 32'(vecs[i].em));
            chk($sformatf("tbl%0d_busy", i), 32'(b), 32'(vecs[i].eb));
            chk($sformatf("tbl%0d_missed", i), 32'(mc), 32'(vecs[i].emc));
        end

        // vibrate_mode toggling every cycle
        for (int c = 0; c < 9; c++) begin
            apply(1'b1, c[0], 1'b0, 1'b0, r, m, b, mc);
            if (c >= 1 && c <= 4) chk($sformatf("tog_excl_c%0d", c), 32'(r ^ m), 32'd1);
            if (c == 5 || c == 6) chk($sformatf("tog_off_c%0d", c), 32'(r | m), 32'd0);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, r, m, b, mc);
        apply(1'b0, 1'b0, 1'b0, 1'b0, r, m, b, mc);
        chk("tog_drop_missed", 32'(mc), 32'd1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, r, m, b, mc);

        // Vibrate call: third burst escalates only when the macro is defined
        for (int c = 0; c < 20; c++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, r, m, b, mc);
            if (c >= 13 && c <= 16) begin
                chk($sformatf("esc_ringer_c%0d", c), 32'(r), 32'(ESC_EN));
                chk($sformatf("esc_motor_c%0d", c), 32'(m), 32'd1);
            end
            if (c >= 1 && c <= 4) chk($sformatf("vib_ringer_c%0d", c), 32'(r), 32'd0);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, r, m, b, mc);
        apply(1'b0, 1'b1, 1'b0, 1'b0, r, m, b, mc);

        // Random run against the model
        rr_p = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) rr_p = ~rr_p;
            apply(rr_p, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 39) == 0), r, m, b, mc);
            if (!ESC_EN) chk("rand_onehot", 32'(r & m), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
